roi_crop: RTL and testbench

Streaming region-of-interest cropper sitting directly downstream of the APB ROI register block. Consumes its two 32-bit coordinate words (xy_0/xy_1) and a raster pixel stream with start-of-frame/end-of-line markers. Forwards only pixels inside the inclusive rectangle, with regenerated frame markers. Coordinates are sampled once per frame, so APB writes mid-frame never tear the crop window.

---
 rtl/roi_crop.sv | 145 ++++++++++++++
 tb/tb_roi_crop.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roi_crop.sv
// Streaming ROI cropper: forwards raster pixels inside an inclusive rectangle latched at sof.
// Optional output statistics on pix_cnt_o are built when ROI_CROP_STATS_EN is defined.
//
// state     | meaning
// ST_IDLE   | after reset, no frame seen yet; drop beats until sof
// ST_ACTIVE | inside a frame, forward in-ROI beats
// ST_DRAIN  | ROI complete or empty; drop beats until next sof
module roi_crop #(
    parameter int PIX_W   = 8,
    parameter int COORD_W = 16
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [31:0]      xy_0_i,
    input  logic [31:0]      xy_1_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [PIX_W-1:0] s_data_i,
    input  logic             s_sof_i,
    input  logic             s_eol_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [PIX_W-1:0] m_data_o,
    output logic             m_sof_o,
    output logic             m_eol_o,
    output logic             frame_done_o,
    output logic [31:0]      pix_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t state_q;

    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic [COORD_W-1:0] ex0, ey0, ex1, ey1;
    logic [COORD_W-1:0] cur_x, cur_y, nxt_x, nxt_y;
    logic               accept, live, roi_empty, in_roi, at_end, fwd, done_evt;

    assign s_ready_o = arst_i & (~m_valid_o | m_ready_i);
    assign accept    = s_valid_i & s_ready_o;

    // A sof beat sits at (0,0) and is judged against the corners it is latching.
    assign ex0   = s_sof_i ? xy_0_i[COORD_W-1:0]    : x0_q;
    assign ey0   = s_sof_i ? xy_0_i[16 +: COORD_W]  : y0_q;
    assign ex1   = s_sof_i ? xy_1_i[COORD_W-1:0]    : x1_q;
    assign ey1   = s_sof_i ? xy_1_i[16 +: COORD_W]  : y1_q;
    assign cur_x = s_sof_i ? '0 : x_q;
    assign cur_y = s_sof_i ? '0 : y_q;

    assign roi_empty = (ex0 > ex1) | (ey0 > ey1);
    assign in_roi    = (cur_x >= ex0) & (cur_x <= ex1) & (cur_y >= ey0) & (cur_y <= ey1);
    assign at_end    = (cur_x == ex1) & (cur_y == ey1);
    assign live      = s_sof_i | (state_q == ST_ACTIVE);
    assign fwd       = accept & live & ~roi_empty & in_roi;
    assign done_evt  = accept & live & (roi_empty ? s_sof_i : at_end);

    assign nxt_x = s_eol_i ? '0
                 : ((cur_x == '1) ? cur_x : cur_x + COORD_W'(1));
    assign nxt_y = s_eol_i ? ((cur_y == '1) ? cur_y : cur_y + COORD_W'(1))
                 : cur_y;

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q      <= ST_IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= done_evt;
            if (accept) begin
                x_q <= nxt_x;
                y_q <= nxt_y;
                if (s_sof_i) begin
                    x0_q    <= ex0;
                    y0_q    <= ey0;
                    x1_q    <= ex1;
                    y1_q    <= ey1;
                    state_q <= done_evt ? ST_DRAIN : ST_ACTIVE;
                end else if (state_q == ST_ACTIVE && at_end) begin
                    state_q <= ST_DRAIN;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_sof_o   <= 1'b0;
            m_eol_o   <= 1'b0;
        end else if (fwd) begin
            m_valid_o <= 1'b1;
            m_data_o  <= s_data_i;
            m_sof_o   <= (cur_x == ex0) & (cur_y == ey0);
            m_eol_o   <= (cur_x == ex1) | s_eol_i;
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

`ifdef ROI_CROP_STATS_EN
    logic [31:0] beat_cnt_q;
    logic        last_q;
    logic        xfer;

    assign xfer = m_valid_o & m_ready_i;

    // last_q marks that the output register holds the (x1,y1) beat.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            beat_cnt_q <= '0;
            last_q     <= 1'b0;
            pix_cnt_o  <= '0;
        end else begin
            if (fwd)
                last_q <= at_end;
            else if (m_ready_i)
                last_q <= 1'b0;

            if (accept && s_sof_i)
                beat_cnt_q <= '0;
            else if (xfer)
                beat_cnt_q <= beat_cnt_q + 32'd1;

            if (accept && s_sof_i && roi_empty)
                pix_cnt_o <= '0;
            else if (xfer && last_q)
                pix_cnt_o <= beat_cnt_q + 32'd1;
        end
    end
`else
    assign pix_cnt_o = '0;
`endif

endmodule

// File: tb/tb_roi_crop.sv
// Directed bench for roi_crop: frame-level model plus per-cycle output and frame_done checks.
module tb_roi_crop;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eol;
    } beat_t;

`ifdef ROI_CROP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        arst_i = 1'b0;
    logic [31:0] xy_0_i = '0;
    logic [31:0] xy_1_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [7:0]  s_data_i = '0;
    logic        s_sof_i = 1'b0;
    logic        s_eol_i = 1'b0;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic [7:0]  m_data_o;
    logic        m_sof_o;
    logic        m_eol_o;
    logic        frame_done_o;
    logic [31:0] pix_cnt_o;

    roi_crop #(.PIX_W(8), .COORD_W(16)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .xy_0_i(xy_0_i), .xy_1_i(xy_1_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .s_sof_i(s_sof_i), .s_eol_i(s_eol_i), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_sof_o(m_sof_o),
        .m_eol_o(m_eol_o), .frame_done_o(frame_done_o), .pix_cnt_o(pix_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int    errors = 0;
    int    checks = 0;
    int    n_done = 0;
    int    rdy_mode = 0;
    beat_t exp_q[$];
    beat_t log_q[$];
    bit    exp_done = 1'b0;

    int    sx0 = 0, sy0 = 0, sx1 = 0, sy1 = 0, px = 0, py = 0;
    bit    live_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] get_log(input int i);
        if (i < log_q.size()) return log_q[i];
        return 10'h3FF;
    endfunction

    // downstream ready: 0 = always ready, 1 = toggle each cycle, 2 = stalled
    always begin
        @(posedge clk_i);
        #1;
        case (rdy_mode)
            0:       m_ready_i = 1'b1;
            1:       m_ready_i = ~m_ready_i;
            default: m_ready_i = 1'b0;
        endcase
    end

    // Frame model: evaluates each accepted beat against the rectangle latched at its sof.
    always begin
        int cx, cy;
        bit empty;
        @(negedge clk_i);
        #4;
        exp_done = 1'b0;
        if (!arst_i) begin
            exp_q.delete();
            live_m = 1'b0;
            px = 0;
            py = 0;
        end else if (s_valid_i && s_ready_o) begin
            if (s_sof_i) begin
                sx0 = int'(xy_0_i[15:0]);
                sy0 = int'(xy_0_i[31:16]);
                sx1 = int'(xy_1_i[15:0]);
                sy1 = int'(xy_1_i[31:16]);
                cx = 0;
                cy = 0;
                live_m = 1'b1;
            end else begin
                cx = px;
                cy = py;
            end
            empty = (sx0 > sx1) || (sy0 > sy1);
            if (s_sof_i && empty) begin
                exp_done = 1'b1;
                live_m = 1'b0;
            end else if (live_m && cx >= sx0 && cx <= sx1 && cy >= sy0 && cy <= sy1) begin
                exp_q.push_back({s_data_i, (cx == sx0 && cy == sy0), (cx == sx1 || s_eol_i)});
                if (cx == sx1 && cy == sy1) begin
                    exp_done = 1'b1;
                    live_m = 1'b0;
                end
            end
            if (s_eol_i) begin
                px = 0;
                py = (cy < 65535) ? cy + 1 : cy;
            end else begin
                px = (cx < 65535) ? cx + 1 : cx;
                py = cy;
            end
        end
    end

    // Compare process: frame_done every cycle, each output transfer, and hold-while-stalled.
    always begin
        bit         stall_prev;
        logic [9:0] held;
        beat_t      e;
        @(negedge clk_i);
        if (!arst_i) begin
            stall_prev = 1'b0;
        end else begin
            check("frame_done", 32'(frame_done_o), 32'(exp_done));
            if (frame_done_o) n_done++;
            if (stall_prev) begin
                check("stall_valid", 32'(m_valid_o), 32'd1);
                check("stall_beat", 32'({m_data_o, m_sof_o, m_eol_o}), 32'(held));
            end
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_extra: got %0h expected no beat", {m_data_o, m_sof_o, m_eol_o});
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'({m_data_o, m_sof_o, m_eol_o}), 32'(e));
                end
                log_q.push_back({m_data_o, m_sof_o, m_eol_o});
            end
            stall_prev = m_valid_o && !m_ready_i;
            held = {m_data_o, m_sof_o, m_eol_o};
        end
    end

    task automatic drive_beat(input logic [7:0] d, input logic sof, input logic eol);
        bit got;
        got = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_sof_i   = sof;
        s_eol_i   = eol;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk_i);
            #3;
            got = s_ready_o;
            @(posedge clk_i);
            #1;
        end
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_eol_i   = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: s_ready_o got 0 for 100 cycles expected 1");
        end
    endtask

    // Pixel value encodes its position as {y[3:0], x[3:0]}.
    task automatic send_frame(input int w, input int h, input int chg_row);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                if (y == chg_row && x == 0) xy_1_i = 32'h0000_0000;
                drive_beat(8'((y << 4) | x), (x == 0 && y == 0), (x == w - 1));
            end
    endtask

    task automatic clear_obs();
        log_q.delete();
        n_done = 0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
        check("pending_beats", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_m_valid", 32'(m_valid_o), 32'd0);
        check("rst_s_ready", 32'(s_ready_o), 32'd0);
        check("rst_m_data", 32'(m_data_o), 32'd0);
        check("rst_markers", 32'({m_sof_o, m_eol_o}), 32'd0);
        check("rst_done", 32'(frame_done_o), 32'd0);
        check("rst_pix_cnt", pix_cnt_o, 32'd0);
        arst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // basic crop: rows 1-2, cols 2-5 of an 8x4 frame
        xy_0_i = 32'h0001_0002;
        xy_1_i = 32'h0002_0005;
        clear_obs();
        send_frame(8, 4, -1);
        settle(6);
        check("basic_beats", 32'(log_q.size()), 32'd8);
        check("basic_done_cnt", 32'(n_done), 32'd1);
        check("basic_first", 32'(get_log(0)), 32'({8'h12, 1'b1, 1'b0}));
        check("basic_row1_eol", 32'(get_log(3)), 32'({8'h15, 1'b0, 1'b1}));
        check("basic_row2_start", 32'(get_log(4)), 32'({8'h22, 1'b0, 1'b0}));
        check("basic_last", 32'(get_log(7)), 32'({8'h25, 1'b0, 1'b1}));
        check("basic_pix_cnt", pix_cnt_o, STATS ? 32'd8 : 32'd0);

        // APB change mid-frame: current frame keeps its window, next frame sees the new one
        clear_obs();
        send_frame(8, 4, 1);
        settle(6);
        check("apb_cur_beats", 32'(log_q.size()), 32'd8);
        check("apb_cur_first", 32'(get_log(0)), 32'({8'h12, 1'b1, 1'b0}));
        check("apb_cur_done", 32'(n_done), 32'd1);
        clear_obs();
        send_frame(8, 4, -1);
        settle(6);
        check("apb_next_beats", 32'(log_q.size()), 32'd0);
        check("apb_next_done", 32'(n_done), 32'd1);

        // backpressure with downstream ready toggling
        xy_0_i = 32'h0001_0002;
        xy_1_i = 32'h0002_0005;
        rdy_mode = 1;
        clear_obs();
        send_frame(8, 4, -1);
        settle(12);
        check("bp_beats", 32'(log_q.size()), 32'd8);
        check("bp_done", 32'(n_done), 32'd1);
        check("bp_mid", 32'(get_log(5)), 32'({8'h23, 1'b0, 1'b0}));
        check("bp_last", 32'(get_log(7)), 32'({8'h25, 1'b0, 1'b1}));
        check("bp_pix_cnt", pix_cnt_o, STATS ? 32'd8 : 32'd0);
        rdy_mode = 0;
        settle(2);

        // empty ROI
        xy_0_i = 32'h0000_0005;
        xy_1_i = 32'h0000_0002;
        clear_obs();
        send_frame(8, 4, -1);
        settle(6);
        check("empty_beats", 32'(log_q.size()), 32'd0);
        check("empty_done", 32'(n_done), 32'd1);
        check("empty_pix_cnt", pix_cnt_o, 32'd0);

        // short lines closed at their own eol, then an early sof truncates the frame
        xy_0_i = 32'h0000_0000;
        xy_1_i = 32'h0002_0014;
        clear_obs();
        send_frame(10, 2, -1);
        xy_0_i = 32'h0000_0001;
        xy_1_i = 32'h0001_0003;
        send_frame(10, 3, -1);
        settle(6);
        check("short_beats", 32'(log_q.size()), 32'd26);
        check("short_done", 32'(n_done), 32'd1);
        check("short_first", 32'(get_log(0)), 32'({8'h00, 1'b1, 1'b0}));
        check("short_eol0", 32'(get_log(9)), 32'({8'h09, 1'b0, 1'b1}));
        check("short_eol1", 32'(get_log(19)), 32'({8'h19, 1'b0, 1'b1}));
        check("early_sof_first", 32'(get_log(20)), 32'({8'h01, 1'b1, 1'b0}));
        check("early_sof_last", 32'(get_log(25)), 32'({8'h13, 1'b0, 1'b1}));

        // reset while an output beat is held
        xy_0_i = 32'h0000_0000;
        xy_1_i = 32'h0003_0007;
        rdy_mode = 2;
        @(posedge clk_i);
        #1;
        clear_obs();
        drive_beat(8'hA0, 1'b1, 1'b0);
        check("rst_mid_pre_valid", 32'(m_valid_o), 32'd1);
        #2;
        arst_i = 1'b0;
        #1;
        check("rst_mid_valid", 32'(m_valid_o), 32'd0);
        check("rst_mid_data", 32'(m_data_o), 32'd0);
        check("rst_mid_markers", 32'({m_sof_o, m_eol_o}), 32'd0);
        check("rst_mid_ready", 32'(s_ready_o), 32'd0);
        check("rst_mid_done", 32'(frame_done_o), 32'd0);
        check("rst_mid_pix_cnt", pix_cnt_o, 32'd0);
        @(posedge clk_i);
        #1;
        arst_i = 1'b1;
        rdy_mode = 0;
        @(posedge clk_i);
        #1;
        clear_obs();
        drive_beat(8'hB0, 1'b0, 1'b0);
        drive_beat(8'hB1, 1'b0, 1'b0);
        drive_beat(8'hB2, 1'b0, 1'b1);
        settle(4);
        check("post_rst_dropped", 32'(log_q.size()), 32'd0);
        xy_1_i = 32'h0001_0001;
        send_frame(4, 2, -1);
        settle(6);
        check("resync_beats", 32'(log_q.size()), 32'd4);
        check("resync_done", 32'(n_done), 32'd1);
        check("resync_first", 32'(get_log(0)), 32'({8'h00, 1'b1, 1'b0}));
        check("resync_eol", 32'(get_log(1)), 32'({8'h01, 1'b0, 1'b1}));
        check("resync_last", 32'(get_log(3)), 32'({8'h11, 1'b0, 1'b1}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached expected $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
